// File: rtl/mem_pkg.sv
// Shared constants and request/response bundles for the main_memory arbiter.
// Bounds checking is enabled with the MEM_ARB_BOUNDS_EN macro.
package mem_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 9;
    localparam int DEPTH  = 11;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } mem_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves on grant.
// Reset pointer gives requester 0 top priority.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] last;
    logic          found;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(last) + 1 + i) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Every grant is a handshake, since ready is the grant itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IW'(N - 1);
        end else if (|grant) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/main_memory_arbiter.sv
// Round-robin port-A arbiter plus port-B fetch sequencer for main_memory.
// Define MEM_ARB_BOUNDS_EN to suppress and flag accesses at addr >= DEPTH.
module main_memory_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = mem_pkg::ADDR_W,
    parameter int DATA_W = mem_pkg::DATA_W,
    parameter int DEPTH  = mem_pkg::DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    input  logic                    fetch_valid,
    input  logic [ADDR_W-1:0]       fetch_addr,
    output logic                    fetch_rsp_valid,
    output logic [DATA_W-1:0]       fetch_rdata,
    output logic                    wen_A,
    output logic                    ren_A,
    output logic [ADDR_W-1:0]       addr_A,
    output logic [DATA_W-1:0]       wdata_A,
    input  logic [DATA_W-1:0]       rdata_A,
    output logic                    ren_B,
    output logic [ADDR_W-1:0]       addr_B,
    input  logic [DATA_W-1:0]       rdata_B
);

    import mem_pkg::*;

    localparam int TW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [TW-1:0]    gidx;
    logic             hs;
    mem_req_t         sel;
    mem_rsp_t         rsp;
    logic             oob;
    logic             f_oob;

    logic             s1_valid;
    logic             s1_we;
    logic             s1_err;
    logic [TW-1:0]    s1_tag;

    logic             r_valid;
    logic             r_we;
    logic             r_err;
    logic [TW-1:0]    r_tag;

    logic             f_s1;
    logic             f_s1_oob;
    logic             f_s2_oob;

    // Masking requests keeps every grant low while reset is asserted.
    assign arb_req = req_valid & {N_REQ{rst_n}};

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    always_comb begin
        sel.we    = req_we[gidx];
        sel.addr  = req_addr[gidx*ADDR_W +: ADDR_W];
        sel.wdata = req_wdata[gidx*DATA_W +: DATA_W];
    end

`ifdef MEM_ARB_BOUNDS_EN
    assign oob   = (int'(sel.addr) >= DEPTH);
    assign f_oob = (int'(fetch_addr) >= DEPTH);
`else
    assign oob   = 1'b0;
    assign f_oob = 1'b0;
`endif

    // Issue stage: drive main_memory port A one edge after the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
            s1_tag   <= '0;
            wen_A    <= 1'b0;
            ren_A    <= 1'b0;
            addr_A   <= '0;
            wdata_A  <= '0;
        end else begin
            s1_valid <= hs;
            wen_A    <= hs & sel.we & ~oob;
            ren_A    <= hs & ~sel.we & ~oob;
            if (hs) begin
                addr_A  <= sel.addr;
                wdata_A <= sel.wdata;
                s1_tag  <= gidx;
                s1_we   <= sel.we;
                s1_err  <= oob;
            end
        end
    end

    // Response stage: memory returns rdata_A during this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_tag   <= '0;
        end else begin
            r_valid <= s1_valid;
            r_we    <= s1_we;
            r_err   <= s1_err;
            r_tag   <= s1_tag;
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp.rdata = '0;
        rsp.err   = 1'b0;
        if (r_valid) begin
            rsp_valid[r_tag] = 1'b1;
            rsp.err          = r_err;
            if (!r_we && !r_err) begin
                rsp.rdata = rdata_A;
            end
        end
    end

    assign rsp_rdata = rsp.rdata;
    assign rsp_err   = rsp.err;

    // Port B: always ready, independent of port A traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_B           <= 1'b0;
            addr_B          <= '0;
            f_s1            <= 1'b0;
            f_s1_oob        <= 1'b0;
            f_s2_oob        <= 1'b0;
            fetch_rsp_valid <= 1'b0;
        end else begin
            ren_B           <= fetch_valid & ~f_oob;
            f_s1            <= fetch_valid;
            fetch_rsp_valid <= f_s1;
            f_s2_oob        <= f_s1_oob;
            if (fetch_valid) begin
                addr_B   <= fetch_addr;
                f_s1_oob <= f_oob;
            end
        end
    end

    assign fetch_rdata =
        (fetch_rsp_valid && !f_s2_oob) ? rdata_B : '0;

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed bench for main_memory_arbiter with a behavioural dual-port memory.
// Build with MEM_ARB_BOUNDS_EN to add the out-of-range sequence.
module tb_main_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [17:0] req_addr;
    logic [17:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [8:0]  rsp_rdata;
    logic        rsp_err;
    logic        fetch_valid;
    logic [8:0]  fetch_addr;
    logic        fetch_rsp_valid;
    logic [8:0]  fetch_rdata;
    logic        wen_A;
    logic        ren_A;
    logic [8:0]  addr_A;
    logic [8:0]  wdata_A;
    logic [8:0]  rdata_A;
    logic        ren_B;
    logic [8:0]  addr_B;
    logic [8:0]  rdata_B;

    logic [8:0]  mem [0:511];

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [1:0] v;
        logic [1:0] we;
        logic [8:0] a0;
        logic [8:0] a1;
        logic [8:0] d0;
        logic [8:0] d1;
        logic [1:0] rdy;
        logic [1:0] rsp;
        logic [8:0] rd;
    } vec_t;

    vec_t tbl [12];

    main_memory_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .fetch_valid     (fetch_valid),
        .fetch_addr      (fetch_addr),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rdata     (fetch_rdata),
        .wen_A           (wen_A),
        .ren_A           (ren_A),
        .addr_A          (addr_A),
        .wdata_A         (wdata_A),
        .rdata_A         (rdata_A),
        .ren_B           (ren_B),
        .addr_B          (addr_B),
        .rdata_B         (rdata_B)
    );

    always #5 clk = ~clk;

    // Synchronous memory: reads return the pre-write word.
    always @(posedge clk) begin
        if (wen_A) mem[addr_A] <= wdata_A;
        if (ren_A) rdata_A <= mem[addr_A];
        if (ren_B) rdata_B <= mem[addr_B];
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h",
                     nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic [1:0] v,
                         input logic [1:0] we,
                         input logic [8:0] a0,
                         input logic [8:0] a1,
                         input logic [8:0] d0,
                         input logic [8:0] d1);
        req_valid = v;
        req_we    = we;
        req_addr  = {a1, a0};
        req_wdata = {d1, d0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        tbl[0]  = '{2'b11, 2'b11, 9'h004, 9'h007, 9'h044, 9'h0AA,
                    2'b01, 2'b00, 9'h000};
        tbl[1]  = '{2'b11, 2'b10, 9'h004, 9'h007, 9'h000, 9'h0AA,
                    2'b10, 2'b00, 9'h000};
        tbl[2]  = '{2'b11, 2'b00, 9'h004, 9'h007, 9'h000, 9'h000,
                    2'b01, 2'b01, 9'h000};
        tbl[3]  = '{2'b11, 2'b01, 9'h005, 9'h007, 9'h0C7, 9'h000,
                    2'b10, 2'b10, 9'h000};
        tbl[4]  = '{2'b11, 2'b01, 9'h005, 9'h004, 9'h0C7, 9'h000,
                    2'b01, 2'b01, 9'h044};
        tbl[5]  = '{2'b11, 2'b00, 9'h005, 9'h004, 9'h000, 9'h000,
                    2'b10, 2'b10, 9'h0AA};
        tbl[6]  = '{2'b01, 2'b00, 9'h005, 9'h000, 9'h000, 9'h000,
                    2'b01, 2'b01, 9'h000};
        tbl[7]  = '{2'b01, 2'b01, 9'h003, 9'h000, 9'h1A5, 9'h000,
                    2'b01, 2'b10, 9'h044};
        tbl[8]  = '{2'b01, 2'b00, 9'h003, 9'h000, 9'h000, 9'h000,
                    2'b01, 2'b01, 9'h0C7};
        tbl[9]  = '{2'b00, 2'b00, 9'h000, 9'h000, 9'h000, 9'h000,
                    2'b00, 2'b01, 9'h000};
        tbl[10] = '{2'b00, 2'b00, 9'h000, 9'h000, 9'h000, 9'h000,
                    2'b00, 2'b01, 9'h1A5};
        tbl[11] = '{2'b00, 2'b00, 9'h000, 9'h000, 9'h000, 9'h000,
                    2'b00, 2'b00, 9'h000};

        drive(2'b11, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
        fetch_valid = 1'b0;
        fetch_addr  = '0;

        // Reset values with both requesters asserting valid.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_wen_ren", 32'({wen_A, ren_A, ren_B}), 32'h0);
        chk("reset_rsp", 32'({rsp_valid, rsp_err, fetch_rsp_valid}), 32'h0);
        chk("reset_addr_A", 32'(addr_A), 32'h0);
        chk("reset_wdata_A", 32'(wdata_A), 32'h0);
        chk("reset_addr_B", 32'(addr_B), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].v, tbl[k].we, tbl[k].a0, tbl[k].a1,
                  tbl[k].d0, tbl[k].d1);
            #1;
            chk($sformatf("ready[%0d]", k), 32'(req_ready), 32'(tbl[k].rdy));
            chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid), 32'(tbl[k].rsp));
            chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err), 32'h0);
            if (tbl[k].rsp != 2'b00)
                chk($sformatf("rsp_rdata[%0d]", k), 32'(rsp_rdata), 32'(tbl[k].rd));
            @(negedge clk);
        end

        // Port-A write and port-B read of addr 5 in the same memory cycle.
        drive(2'b01, 2'b01, 9'h005, 9'h000, 9'h111, 9'h000);
        fetch_valid = 1'b1;
        fetch_addr  = 9'h005;
        #1 chk("coll_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
        fetch_valid = 1'b0;
        #1 chk("fetch_early", 32'(fetch_rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("fetch_valid_old", 32'(fetch_rsp_valid), 32'h1);
        chk("fetch_old_data", 32'(fetch_rdata), 32'h0C7);
        chk("coll_wr_rsp", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        fetch_valid = 1'b1;
        fetch_addr  = 9'h005;
        @(negedge clk);
        fetch_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("fetch_valid_new", 32'(fetch_rsp_valid), 32'h1);
        chk("fetch_new_data", 32'(fetch_rdata), 32'h111);

        // Reset one cycle after a read handshake drops the response.
        @(negedge clk);
        drive(2'b01, 2'b00, 9'h003, 9'h000, 9'h000, 9'h000);
        #1 chk("mid_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(2'b11, 2'b00, 9'h003, 9'h003, 9'h000, 9'h000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_wen_ren", 32'({wen_A, ren_A}), 32'h0);
        chk("mid_rst_addr_A", 32'(addr_A), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 if (rsp_valid != 2'b00) seen = 1'b1;
            @(posedge clk);
            #1 if (rsp_valid != 2'b00) seen = 1'b1;
            @(negedge clk);
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'h0);

`ifdef MEM_ARB_BOUNDS_EN
        // Out-of-range read on requester 1 and out-of-range fetch.
        drive(2'b10, 2'b00, 9'h000, 9'h00C, 9'h000, 9'h000);
        fetch_valid = 1'b1;
        fetch_addr  = 9'h00C;
        #1 chk("oob_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        drive(2'b00, 2'b00, 9'h0, 9'h0, 9'h0, 9'h0);
        fetch_valid = 1'b0;
        #1 chk("oob_wen_ren", 32'({wen_A, ren_A, ren_B}), 32'h0);
        @(negedge clk);
        #1;
        chk("oob_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("oob_rsp_err", 32'(rsp_err), 32'h1);
        chk("oob_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("oob_fetch_valid", 32'(fetch_rsp_valid), 32'h1);
        chk("oob_fetch_rdata", 32'(fetch_rdata), 32'h0);
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
Name: main_memory_arbiter

Overview:
- Shares main_memory read/write port A between N_REQ requesters using round-robin arbitration.
- Sequences main_memory read port B for a single instruction-fetch requester.
- Sits between the MIC-1 datapath (MAR/MDR, PC/MBR), the debug/loader unit and main_memory.
- Pipelined: one port-A access can be accepted per cycle, with up to 2 accesses in flight.

Parameters:
- N_REQ, 2: number of port-A requesters (index 0 = datapath, 1 = loader).
- ADDR_W, 9: address width.
- DATA_W, 9: data width.
- DEPTH, 11: number of populated memory words (used only under MEM_ARB_BOUNDS_EN).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester port-A request.
- req_we  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*ADDR_W  packed request addresses, requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  packed write data, same packing rule.
- req_ready  out  N_REQ  one-hot grant; handshake = valid & ready.
- rsp_valid  out  N_REQ  one-cycle response pulse to the owning requester.
- rsp_rdata  out  DATA_W  read data, valid when any rsp_valid bit is high.
- rsp_err  out  1  out-of-range flag, qualified by rsp_valid.
- fetch_valid  in  1  port-B fetch request.
- fetch_addr  in  ADDR_W  port-B fetch address.
- fetch_rsp_valid  out  1  fetch data valid.
- fetch_rdata  out  DATA_W  fetched word.
- wen_A, ren_A  out  1 each  to main_memory.
- addr_A  out  ADDR_W  to main_memory.
- wdata_A  out  DATA_W  to main_memory.
- rdata_A  in  DATA_W  from main_memory.
- ren_B  out  1  to main_memory.
- addr_B  out  ADDR_W  to main_memory.
- rdata_B  in  DATA_W  from main_memory.

Behaviour:
- Reset values (asynchronous, while rst_n = 0): wen_A, ren_A, ren_B, all rsp_valid, rsp_err and fetch_rsp_valid are 0; addr_A, addr_B and wdata_A are 0; round-robin pointer gives requester 0 top priority.
- Reset mid-operation: in-flight responses are dropped, with no pulse after reset releases.
- req_ready is combinational from req_valid and the round-robin pointer.
  - At most one bit is high, and only for a valid requester.
  - Nothing is granted while rst_n = 0.
- Round-robin arbitration:
  - Search starts at the index after the last granted requester.
  - The pointer updates only on a handshake.
  - Any single valid requester is granted in the same cycle.
- Requesters hold req_we, req_addr and req_wdata stable while valid & !ready.
- Issue stage: on handshake edge H, the registers are loaded as follows:
  - wen_A = req_we[g] and ren_A = !req_we[g];
  - addr_A and wdata_A are loaded from the granted requester;
  - a tag register records the granted requester.
  - With no handshake at H, wen_A and ren_A are 0 for the next cycle and addr_A/wdata_A hold.
- Memory stage: main_memory performs the access at edge H+1; rdata_A is valid after H+1.
- Response stage:
  - rsp_valid[tag] is high for exactly the cycle after edge H+1.
  - Latency is 2 edges from handshake to response.
  - rsp_rdata = rdata_A for reads and 0 for writes.
  - Responses cannot be back-pressured; requesters must accept them.
- Throughput: back-to-back handshakes are allowed, so one request per cycle is sustained.
- Ordering: port-A accesses complete in grant order, so read-after-write to the same address through port A returns the new data.
- Port B:
  - On an edge where fetch_valid = 1, ren_B = 1 and addr_B = fetch_addr are registered.
  - fetch_rsp_valid pulses in the cycle after the following edge, with fetch_rdata = rdata_B.
  - Port B is always ready, has no arbitration, and is independent of port A.
- Simultaneous port-A write and port-B read of the same address in the same memory cycle: port B returns the old data.

Optional Feature:
- Macro: MEM_ARB_BOUNDS_EN.
- Defined:
  - A port-A request with addr >= DEPTH is still handshaken and tagged, but wen_A and ren_A stay 0.
  - Its response pulses at the normal latency with rsp_err = 1 and rsp_rdata = 0.
  - An out-of-range fetch returns fetch_rdata = 0.
- Undefined: rsp_err is tied to 0 and all addresses are passed through unchanged.

Decomposition:
- Package mem_pkg holds:
  - ADDR_W, DATA_W and DEPTH constants;
  - typedef mem_req_t {we, addr, wdata};
  - typedef mem_rsp_t {rdata, err}.
- Sub-module rr_arbiter (parameter N) contains the round-robin pointer and grant logic; it is reused by later shared resources.

Test Plan:
- Reset with both requesters valid -> all req_ready = 0; after rst_n rises, req 0 is granted first and req 1 on the next cycle.
- Req 0 writes 0x1A5 to addr 3 at edge H, then req 0 reads addr 3 at H+1 -> rsp_valid[0] in cycles H+2 and H+3, second rsp_rdata = 0x1A5.
- Both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1 and rsp_valid is tagged to match.
- Fetch addr 5 preloaded with 0x0C7 while port A writes addr 5 with 0x111 in the same memory cycle -> fetch_rdata = 0x0C7; a later fetch returns 0x111.
- rst_n dropped one cycle after a read handshake -> no rsp_valid is ever observed for that read.
- MEM_ARB_BOUNDS_EN defined, req 1 reads addr 12 -> wen_A and ren_A stay 0; rsp_valid[1] with rsp_err = 1 and rsp_rdata = 0.
